alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the lab ALU.
- Keeps the one-hot function select and all 12 single-cycle operations.
- Adds iterative unsigned multiply, divide and remainder, a registered result, and valid/ready handshakes on the input and output sides.
- Sits between the operand-fetch stage and the writeback register in the lab datapath.

---
 rtl/alu_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Multi-cycle ALU with one-hot function select. Twelve
//             single-cycle operations plus iterative unsigned multiply
//             (shift-add), divide and remainder (restoring division).
//             Registered result with valid/ready handshakes on both sides.
//             WIDTH must be a power of 2 and at least 8.
//  Ports    : clk        system clock, rising edge
//             rstn       asynchronous active-low reset
//             in_valid   operands and f are valid
//             in_ready   block can accept an operation (IDLE only)
//             f[NF]      one-hot op select
//             a, b       operands
//             out_valid  y is valid (DONE)
//             out_ready  consumer accepts y
//             y          registered result
//             busy       iterative op in progress
//             flag_z/n/v result flags (only with ALU_SEQ_FLAGS_EN defined)
//  Options  : `define ALU_SEQ_FLAGS_EN adds registered zero/negative/overflow
//             flags; without it the flag ports and logic are absent.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH),
  localparam int NF    = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NF-1:0]    f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL accumulator / division remainder
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand / dividend-quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier / divisor
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_mul_q, is_mul_d;
  logic             is_rem_q, is_rem_d;

  // ---------------- single-cycle datapath (operands straight from inputs)
  logic [WIDTH-1:0] sum, diff, sc_res, sc_y;
  logic [WIDTH:0]   sub_full;
  logic             slt, sltu, f_legal, f_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] ops [NF];

  assign sum      = a + b;
  // SUB, SLT and SLTU share this one adder; bit WIDTH is the carry out.
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff     = sub_full[WIDTH-1:0];
  assign slt      = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
  assign sltu     = ~sub_full[WIDTH];
  assign shamt    = b[SHW-1:0];
  assign f_legal  = (f != '0) && ((f & (f - NF'(1))) == '0);
  assign f_iter   = f_legal && (f[12] || f[13] || f[14]);

  always_comb begin
    ops[0]  = sum;
    ops[1]  = diff;
    ops[2]  = {{(WIDTH-1){1'b0}}, slt};
    ops[3]  = {{(WIDTH-1){1'b0}}, sltu};
    ops[4]  = a & b;
    ops[5]  = a | b;
    ops[6]  = ~(a | b);
    ops[7]  = a ^ b;
    ops[8]  = a << shamt;
    ops[9]  = a >> shamt;
    ops[10] = $signed(a) >>> shamt;
    ops[11] = b;
    ops[12] = '0;
    ops[13] = '0;
    ops[14] = '0;
  end

  // With a legal one-hot select exactly one term survives the OR.
  always_comb begin
    sc_res = '0;
    for (int i = 0; i < NF; i++) begin
      if (f[i]) sc_res = sc_res | ops[i];
    end
  end

  assign sc_y = f_legal ? sc_res : '0;

  // ---------------- iterative datapath (one step per BUSY cycle)
  logic [WIDTH-1:0] mul_acc, rem_next, quo_next, iter_y;
  logic [WIDTH:0]   rshift;
  logic             div_ge, last;

  assign mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
  // Restoring division: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. A zero divisor always fits, which
  // yields an all-ones quotient and a remainder equal to the dividend.
  assign rshift   = {acc_q, opa_q[WIDTH-1]};
  assign div_ge   = rshift >= {1'b0, opb_q};
  assign rem_next = div_ge ? (rshift[WIDTH-1:0] - opb_q) : rshift[WIDTH-1:0];
  assign quo_next = {opa_q[WIDTH-2:0], div_ge};
  assign iter_y   = is_mul_q ? mul_acc : (is_rem_q ? rem_next : quo_next);
  assign last     = (cnt_q == SHW'(WIDTH-1));

`ifdef ALU_SEQ_FLAGS_EN
  logic fz_q, fz_d, fn_q, fn_d, fv_q, fv_d;
  logic sc_v;

  assign sc_v = f_legal &&
                ((f[0] && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1])) ||
                 (f[1] && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])));
`endif

  // ---------------- next-state / datapath control
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
`ifdef ALU_SEQ_FLAGS_EN
    fz_d     = fz_q;
    fn_d     = fn_q;
    fv_d     = fv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (f_iter) begin
            state_d  = S_BUSY;
            acc_d    = '0;
            opa_d    = a;
            opb_d    = b;
            cnt_d    = '0;
            is_mul_d = f[12];
            is_rem_d = f[14];
          end else begin
            state_d  = S_DONE;
            y_d      = sc_y;
`ifdef ALU_SEQ_FLAGS_EN
            fz_d     = (sc_y == '0);
            fn_d     = sc_y[WIDTH-1];
            fv_d     = sc_v;
`endif
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + SHW'(1);
        if (is_mul_q) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = rem_next;
          opa_d = quo_next;
        end
        if (last) begin
          state_d = S_DONE;
          y_d     = iter_y;
`ifdef ALU_SEQ_FLAGS_EN
          fz_d    = (iter_y == '0);
          fn_d    = iter_y[WIDTH-1];
          fv_d    = 1'b0;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      is_rem_q <= is_rem_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      fz_q <= fz_d;
      fn_q <= fn_d;
      fv_q <= fv_d;
    end
  end

  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign flag_v = fv_q;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=32). Expected results
//             are pushed to a scoreboard queue at accept and popped when
//             out_valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 32;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [14:0]   f         = '0;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic          in_ready, out_valid, busy;
  logic [W-1:0]  y;
`ifdef ALU_SEQ_FLAGS_EN
  logic          flag_z, flag_n, flag_v;
`endif

  typedef struct packed {
    logic [W-1:0] y;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f         (f),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural reference for random vectors.
  function automatic logic [W-1:0] model_y(input logic [14:0] fv, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [63:0]  p;
    logic [W-1:0] r;
    p = {32'b0, av} * {32'b0, bv};
    case (fv)
      15'h0001: r = av + bv;
      15'h0002: r = av - bv;
      15'h0004: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      15'h0008: r = (av < bv) ? 32'd1 : 32'd0;
      15'h0010: r = av & bv;
      15'h0020: r = av | bv;
      15'h0040: r = ~(av | bv);
      15'h0080: r = av ^ bv;
      15'h0100: r = av << bv[4:0];
      15'h0200: r = av >> bv[4:0];
      15'h0400: r = $signed(av) >>> bv[4:0];
      15'h0800: r = bv;
      15'h1000: r = p[31:0];
      15'h2000: r = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
      15'h4000: r = (bv == 0) ? av : av % bv;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_v(input logic [14:0] fv, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic signed [W:0] s;
    s = '0;
    if (fv == 15'h0001) s = $signed({av[W-1], av}) + $signed({bv[W-1], bv});
    if (fv == 15'h0002) s = $signed({av[W-1], av}) - $signed({bv[W-1], bv});
    return s[W] ^ s[W-1];
  endfunction

  task automatic run_op(input string tag, input logic [14:0] fv, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ey, input int hold);
    int   lat, busy_n, wt;
    logic ir_seen, iter;
    logic [W-1:0] y_hold;
    exp_t e;
    iter = (fv == 15'h1000) || (fv == 15'h2000) || (fv == 15'h4000);
    wt = 0;
    while (!in_ready && wt < 100) begin
      @(posedge clk); #1; wt++;
    end
    if (!in_ready) chk({tag, ":rdy_timeout"}, {31'b0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    f = fv; a = av; b = bv; in_valid = 1'b1;
    sb.push_back('{y: ey, v: model_v(fv, av, bv)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_n = 0; ir_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk({tag, ":lat"}, 32'(lat), iter ? 32'd33 : 32'd1);
    if (iter) begin
      chk({tag, ":busy_cyc"}, 32'(busy_n), 32'd32);
      chk({tag, ":rdy_low"}, {31'b0, ir_seen}, 32'd0);
    end
    if (sb.size() == 0) begin
      chk({tag, ":sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ":y"}, y, e.y);
`ifdef ALU_SEQ_FLAGS_EN
      chk({tag, ":z"}, {31'b0, flag_z}, {31'b0, (e.y == 0)});
      chk({tag, ":n"}, {31'b0, flag_n}, {31'b0, e.y[W-1]});
      chk({tag, ":v"}, {31'b0, flag_v}, {31'b0, e.v});
`endif
    end
    if (hold > 0) begin
      // Stall the consumer and offer a new op that must not be taken.
      y_hold = y;
      f = 15'h0001; a = 32'd9; b = 32'd9; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, ":hold_y"}, y, y_hold);
        chk({tag, ":hold_ov"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ":hold_ir"}, {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ":ov_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ":ir_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0]  rf;
    logic [W-1:0] ra, rb;
    int           k;

    // Reset state, including across clock edges while held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", {31'b0, in_ready}, 32'd1);
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_y", y, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 15'h0001, 32'hFFFF_FFFF, 32'd1,        32'd0,         0);
    run_op("slt",      15'h0004, 32'h8000_0000, 32'd1,        32'd1,         0);
    run_op("sltu",     15'h0008, 32'h8000_0000, 32'd1,        32'd0,         0);
    run_op("sra",      15'h0400, 32'h8000_0000, 32'h24,       32'hF800_0000, 0);
    run_op("mul",      15'h1000, 32'h0001_0003, 32'h5,        32'h0005_000F, 0);
    run_op("divu",     15'h2000, 32'd100,       32'd7,        32'd14,        0);
    run_op("remu",     15'h4000, 32'd100,       32'd7,        32'd2,         0);
    run_op("divu_z",   15'h2000, 32'h1234,      32'd0,        32'hFFFF_FFFF, 0);
    run_op("remu_z",   15'h4000, 32'h1234,      32'd0,        32'h1234,      0);
    run_op("sub_neg",  15'h0002, 32'd5,         32'd7,        32'hFFFF_FFFE, 0);
    run_op("add_ovf",  15'h0001, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 0);
    run_op("ill_zero", 15'h0000, 32'h55,        32'h66,       32'd0,         0);
    run_op("ill_two",  15'h0003, 32'h55,        32'h66,       32'd0,         0);
    run_op("ill_iter", 15'h3000, 32'h55,        32'h66,       32'd0,         0);
    run_op("passb",    15'h0800, 32'h1,         32'hDEAD,     32'hDEAD,      0);
    run_op("sll_hib",  15'h0100, 32'h1,         32'h21,       32'd2,         0);
    run_op("srl",      15'h0200, 32'h8000_0000, 32'd31,       32'd1,         0);
    run_op("nor",      15'h0040, 32'd0,         32'd0,        32'hFFFF_FFFF, 0);
    run_op("xor_bp",   15'h0080, 32'hF0F0,      32'h0FF0,     32'hFF00,      5);
    run_op("mul_bp",   15'h1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        5);

    // Reset asserted at BUSY cycle 10 aborts the op.
    f = 15'h1000; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_ov", {31'b0, out_valid}, 32'd0);
    chk("mid_ir", {31'b0, in_ready}, 32'd1);
    chk("mid_busy0", {31'b0, busy}, 32'd0);
    chk("mid_y", y, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_op("add_post", 15'h0001, 32'd2, 32'd3, 32'd5, 0);

    // Random vectors against the behavioural model.
    for (int i = 0; i < 20; i++) begin
      k  = $urandom_range(0, 15);
      rf = (k == 15) ? 15'h0030 : 15'(1 << k);
      ra = $urandom();
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      run_op("rand", rf, ra, rb, model_y(rf, ra, rb), 0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
